por_sequencer: RTL and testbench
================================

// Module: por_sequencer
// PURPOSE
//  Parametrised power-on reset sequencer; successor to the single-output POR delay.
//  Waits for a synchronised power-good, then releases NUM_STAGES reset outputs one by one, STAGE_DLY cycles apart.
//  Re-asserts every output at once on power-good loss or a reset request.
//  Sits at the top level and drives the reset of each clock-domain/subsystem; downstream domains re-synchronise.
// PARAMETERS
//  NUM_STAGES   4       number of sequenced reset outputs, >=1
//  CNT_W        16      delay counter width; STAGE_DLY must be <= 2**CNT_W-1
//  STAGE_DLY    30000   clock cycles between successive releases, >=1
//  SYNC_STAGES  3       flop depth of iPwrGood/iRstReq synchronisers, >=2
//  ACK_TMO      65535   ack-wait timeout in cycles (used only with POR_SEQ_ACK_EN)
// PORTS
//  iClk         in   1              sequencer clock
//  iRst_n       in   1              synchronous active-low reset
//  iPwrGood     in   1              async power-good, active high
//  iRstReq      in   1              async software/button reset request, active high
//  oStageRst_n  out  NUM_STAGES     per-stage reset, active low; bit k released k-th
//  oStage       out  $clog2(NUM_STAGES+1)  number of stages released so far
//  oDone        out  1              all stages released
//  oFault       out  1              ack timeout (tied 0 without POR_SEQ_ACK_EN)
// BEHAVIOUR
//  - Reset (iRst_n=0 at edge): oStageRst_n=0, oStage=0, oDone=0, oFault=0, cnt=0, synchronisers=0, state=WAIT_PG.
//  - pg_s/req_s = last flop of SYNC_STAGES-deep chain; all decisions use pg_s/req_s only.
//  - States: WAIT_PG, COUNT, (WAIT_ACK), DONE, HOLD.
//  - WAIT_PG: cnt=0; if pg_s & ~req_s -> COUNT.
//  - COUNT: cnt+1 each edge; at cnt==STAGE_DLY-1: oStageRst_n[oStage]<=1, oStage+1, cnt<=0;
//    if that was stage NUM_STAGES-1 -> DONE with oDone<=1 on the same edge, else stay COUNT.
//  - Timing: E0 = first edge sampling iPwrGood=1 (held high). Stage k released at edge E0+SYNC_STAGES+(k+1)*STAGE_DLY.
//  - DONE: outputs held; counter idle.
//  - Abort (any state except reset): ~pg_s or req_s -> next edge oStageRst_n=0, oStage=0, oDone=0, cnt=0;
//    state HOLD if req_s else WAIT_PG. HOLD -> WAIT_PG once req_s=0. Abort beats a release due on the same edge.
//  - iRst_n mid-sequence: identical to reset; no partial release survives.
//  - oStageRst_n bits only go 0->1 in ascending order; never more than one bit changes per edge on release.
//  - Outputs registered; no combinational path from inputs to outputs.
//  - Glitches on iPwrGood shorter than one clock may be missed; any sampled low aborts (no debounce).
// CONFIGURATION
//  POR_SEQ_ACK_EN defined: adds input iStageAck [NUM_STAGES] (async, synchronised like iPwrGood).
//   After releasing stage k (k<NUM_STAGES-1) enter WAIT_ACK; next stage count starts on the edge synced ack[k] seen high.
//   Last stage: wait for ack[NUM_STAGES-1] before oDone<=1.
//   WAIT_ACK timeout: ACK_TMO cycles without ack -> oFault<=1, all resets reasserted, state HOLD until iRst_n
//   (oFault cleared only by iRst_n). Abort rules still apply.
//  Not defined: no iStageAck port, no WAIT_ACK state, oFault constant 0, pure timed sequence.
// TESTING (NUM_STAGES=4, STAGE_DLY=10, SYNC_STAGES=3)
//  1 iRst_n low 2 cycles, iPwrGood=1 from E0 -> oStageRst_n 0001@E0+13, 0011@+23, 0111@+33, 1111+oDone@+43.
//  2 iPwrGood never high -> all outputs stay 0 for 1000 cycles.
//  3 After oDone, drop iPwrGood 1 cycle -> 3 edges later all 0, oDone=0; restarts, stage0 at +13 after re-high.
//  4 iRstReq pulsed at stage 2 for 5 cycles -> outputs 0 after sync; held until req low; restart full sequence.
//  5 iRst_n low mid-COUNT (oStage=2) -> next edge all outputs 0; sequence restarts from stage 0.
//  6 ACK_EN, ACK_TMO=20: ack[0] never -> oFault=1 at release+20, all 0; only iRst_n clears it.

Source files
------------

// File: rtl/por_sequencer.sv
// por_sequencer: after a synchronised power-good, releases NUM_STAGES active-low resets one by one, STAGE_DLY cycles apart.
// Registered outputs. Defining POR_SEQ_ACK_EN adds a per-stage acknowledge wait, with a timeout that sets oFault.
module por_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int CNT_W       = 16,
  parameter int STAGE_DLY   = 30000,
  parameter int SYNC_STAGES = 3,
  parameter int ACK_TMO     = 65535
) (
  input  logic                              iClk,
  input  logic                              iRst_n,
  input  logic                              iPwrGood,
  input  logic                              iRstReq,
`ifdef POR_SEQ_ACK_EN
  input  logic [NUM_STAGES-1:0]             iStageAck,
`endif
  output logic [NUM_STAGES-1:0]             oStageRst_n,
  output logic [$clog2(NUM_STAGES+1)-1:0]   oStage,
  output logic                              oDone,
  output logic                              oFault
);
  localparam int STG_W = $clog2(NUM_STAGES+1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY-1);

`ifdef POR_SEQ_ACK_EN
  typedef enum logic [2:0] {WAIT_PG, COUNT, WAIT_ACK, DONE, HOLD} state_t;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TMO-1);
  localparam logic [STG_W-1:0] STG_ALL  = STG_W'(NUM_STAGES);
`else
  typedef enum logic [2:0] {WAIT_PG, COUNT, DONE, HOLD} state_t;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES-1);
`endif

  state_t state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic [NUM_STAGES-1:0] rstNxt;
  logic [STG_W-1:0] stageNxt;
  logic doneNxt;
  logic [SYNC_STAGES-1:0] pgSync, reqSync;
  logic pgS, reqS, abort;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      pgSync  <= '0;
      reqSync <= '0;
    end else begin
      pgSync  <= {pgSync[SYNC_STAGES-2:0], iPwrGood};
      reqSync <= {reqSync[SYNC_STAGES-2:0], iRstReq};
    end
  end

  assign pgS   = pgSync[SYNC_STAGES-1];
  assign reqS  = reqSync[SYNC_STAGES-1];
  assign abort = ~pgS | reqS;

`ifdef POR_SEQ_ACK_EN
  logic [NUM_STAGES-1:0] ackSync [SYNC_STAGES];
  logic [NUM_STAGES-1:0] ackS;
  logic ackSel, faultQ, faultNxt;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) ackSync[i] <= '0;
    end else begin
      ackSync[0] <= iStageAck;
      for (int i = 1; i < SYNC_STAGES; i++) ackSync[i] <= ackSync[i-1];
    end
  end

  assign ackS = ackSync[SYNC_STAGES-1];

  // Ack of the most recently released stage (oStage already points one past it)
  always_comb begin
    ackSel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (oStage == STG_W'(i+1)) ackSel = ackS[i];
  end

  assign oFault = faultQ;
`else
  localparam logic faultQ = 1'b0;
  assign oFault = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state       <= WAIT_PG;
      cnt         <= '0;
      oStageRst_n <= '0;
      oStage      <= '0;
      oDone       <= 1'b0;
`ifdef POR_SEQ_ACK_EN
      faultQ      <= 1'b0;
`endif
    end else begin
      state       <= stateNxt;
      cnt         <= cntNxt;
      oStageRst_n <= rstNxt;
      oStage      <= stageNxt;
      oDone       <= doneNxt;
`ifdef POR_SEQ_ACK_EN
      faultQ      <= faultNxt;
`endif
    end
  end

  always_comb begin
    stateNxt = state;
    if (faultQ)
      stateNxt = HOLD;
    else if (abort)
      stateNxt = reqS ? HOLD : WAIT_PG;
    else begin
      case (state)
        WAIT_PG: stateNxt = COUNT;
        COUNT: begin
          if (cnt == DLY_LAST) begin
`ifdef POR_SEQ_ACK_EN
            stateNxt = WAIT_ACK;
`else
            stateNxt = (oStage == STG_LAST) ? DONE : COUNT;
`endif
          end
        end
`ifdef POR_SEQ_ACK_EN
        WAIT_ACK: begin
          if (ackSel)                stateNxt = (oStage == STG_ALL) ? DONE : COUNT;
          else if (cnt == TMO_LAST)  stateNxt = HOLD;
        end
`endif
        HOLD:    stateNxt = WAIT_PG;
        default: stateNxt = state;
      endcase
    end
  end

  // Abort clears everything and takes priority over a release due on the same edge
  always_comb begin
    rstNxt   = oStageRst_n;
    stageNxt = oStage;
    doneNxt  = oDone;
    cntNxt   = '0;
`ifdef POR_SEQ_ACK_EN
    faultNxt = faultQ;
`endif
    if (abort || faultQ) begin
      rstNxt   = '0;
      stageNxt = '0;
      doneNxt  = 1'b0;
    end else begin
      case (state)
        COUNT: begin
          if (cnt == DLY_LAST) begin
            for (int i = 0; i < NUM_STAGES; i++)
              if (oStage == STG_W'(i)) rstNxt[i] = 1'b1;
            stageNxt = oStage + 1'b1;
`ifndef POR_SEQ_ACK_EN
            doneNxt  = (oStage == STG_LAST);
`endif
          end else begin
            cntNxt = cnt + 1'b1;
          end
        end
`ifdef POR_SEQ_ACK_EN
        WAIT_ACK: begin
          if (ackSel) begin
            doneNxt = (oStage == STG_ALL);
          end else if (cnt == TMO_LAST) begin
            faultNxt = 1'b1;
            rstNxt   = '0;
            stageNxt = '0;
          end else begin
            cntNxt = cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_por_sequencer.sv
// Directed bench for por_sequencer with NUM_STAGES=4, STAGE_DLY=10, SYNC_STAGES=3.
module tb_por_sequencer;
  localparam int NS = 4;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iPwrGood;
  logic          iRstReq;
  logic [NS-1:0] oStageRst_n;
  logic [2:0]    oStage;
  logic          oDone;
  logic          oFault;
`ifdef POR_SEQ_ACK_EN
  logic [NS-1:0] iStageAck;
`endif

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  por_sequencer #(
    .NUM_STAGES(NS), .CNT_W(16), .STAGE_DLY(10), .SYNC_STAGES(3), .ACK_TMO(20)
  ) dut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iPwrGood(iPwrGood),
    .iRstReq(iRstReq),
`ifdef POR_SEQ_ACK_EN
    .iStageAck(iStageAck),
`endif
    .oStageRst_n(oStageRst_n),
    .oStage(oStage),
    .oDone(oDone),
    .oFault(oFault)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  // Stages released n edges after E0: stage k lands at E0+13+10k
  function automatic int expStages(input int n);
    int s;
    if (n < 13) return 0;
    s = (n - 13) / 10 + 1;
    return (s > NS) ? NS : s;
  endfunction

  function automatic logic [NS-1:0] expMask(input int s);
    logic [NS-1:0] m;
    m = '0;
    for (int i = 0; i < s; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    iRst_n = 1'b0; iPwrGood = 1'b0; iRstReq = 1'b0;
`ifdef POR_SEQ_ACK_EN
    iStageAck = '0;
`endif
    tick(2);
    checks++;
    if (oStageRst_n !== 4'b0000 || oStage !== 3'd0 || oDone !== 1'b0 || oFault !== 1'b0) begin
      errors++;
      $display("FAIL reset rst=%b stage=%0d done=%b fault=%b expected 0000/0/0/0",
               oStageRst_n, oStage, oDone, oFault);
    end
  endtask

  task automatic test_timed_sequence();
    int s;
    iRst_n = 1'b1; iPwrGood = 1'b1;
    for (int n = 0; n <= 45; n++) begin
      tick(1);
      s = expStages(n);
      checks++;
      if (oStageRst_n !== expMask(s) || oStage !== 3'(s) || oDone !== (s == NS) || oFault !== 1'b0) begin
        errors++;
        $display("FAIL sequence E0+%0d rst=%b stage=%0d done=%b fault=%b expected rst=%b stage=%0d done=%b",
                 n, oStageRst_n, oStage, oDone, oFault, expMask(s), s, s == NS);
      end
    end
  endtask

  task automatic test_no_pwrgood();
    iRst_n = 1'b0; iPwrGood = 1'b0; iRstReq = 1'b0;
    tick(2);
    iRst_n = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      tick(1);
      if (n % 50 == 0) begin
        checks++;
        if (oStageRst_n !== 4'b0000 || oStage !== 3'd0 || oDone !== 1'b0) begin
          errors++;
          $display("FAIL no_pwrgood cycle %0d rst=%b stage=%0d done=%b expected all 0",
                   n, oStageRst_n, oStage, oDone);
        end
      end
    end
  endtask

  // Called with the sequence complete; one low sample of iPwrGood
  task automatic test_pg_drop();
    int s;
    iPwrGood = 1'b0;
    for (int n = 0; n <= 52; n++) begin
      tick(1);
      if (n == 0) iPwrGood = 1'b1;
      s = (n < 3) ? NS : expStages(n - 1);
      checks++;
      if (oStageRst_n !== expMask(s) || oStage !== 3'(s) || oDone !== (s == NS)) begin
        errors++;
        $display("FAIL pg_drop F0+%0d rst=%b stage=%0d done=%b expected rst=%b stage=%0d done=%b",
                 n, oStageRst_n, oStage, oDone, expMask(s), s, s == NS);
      end
    end
  endtask

  task automatic test_rst_req();
    int s;
    iRst_n = 1'b0; iPwrGood = 1'b0; iRstReq = 1'b0;
    tick(2);
    iRst_n = 1'b1; iPwrGood = 1'b1;
    tick(24);
    checks++;
    if (oStage !== 3'd2 || oStageRst_n !== 4'b0011) begin
      errors++;
      $display("FAIL rst_req_setup stage=%0d rst=%b expected 2/0011", oStage, oStageRst_n);
    end
    iRstReq = 1'b1;
    for (int r = 0; r <= 52; r++) begin
      tick(1);
      if (r == 4) iRstReq = 1'b0;
      if (r <= 2)       s = 2;
      else if (r < 19)  s = 0;
      else              s = ((r - 19) / 10 + 1 > NS) ? NS : (r - 19) / 10 + 1;
      checks++;
      if (oStageRst_n !== expMask(s) || oStage !== 3'(s) || oDone !== (s == NS)) begin
        errors++;
        $display("FAIL rst_req R0+%0d rst=%b stage=%0d done=%b expected rst=%b stage=%0d done=%b",
                 r, oStageRst_n, oStage, oDone, expMask(s), s, s == NS);
      end
    end
  endtask

  task automatic test_rst_mid();
    int s;
    iRst_n = 1'b0; iPwrGood = 1'b0; iRstReq = 1'b0;
    tick(2);
    iRst_n = 1'b1; iPwrGood = 1'b1;
    tick(24);
    iRst_n = 1'b0;
    tick(1);
    checks++;
    if (oStageRst_n !== 4'b0000 || oStage !== 3'd0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear rst=%b stage=%0d done=%b expected 0000/0/0", oStageRst_n, oStage, oDone);
    end
    iRst_n = 1'b1;
    for (int n = 0; n <= 45; n++) begin
      tick(1);
      s = expStages(n);
      checks++;
      if (oStageRst_n !== expMask(s) || oStage !== 3'(s) || oDone !== (s == NS)) begin
        errors++;
        $display("FAIL rst_mid_restart E0+%0d rst=%b stage=%0d done=%b expected rst=%b stage=%0d",
                 n, oStageRst_n, oStage, oDone, expMask(s), s);
      end
    end
  endtask

`ifdef POR_SEQ_ACK_EN
  task automatic test_ack_timeout();
    iRst_n = 1'b0; iPwrGood = 1'b0; iRstReq = 1'b0; iStageAck = '0;
    tick(2);
    iRst_n = 1'b1; iPwrGood = 1'b1;
    for (int n = 0; n <= 60; n++) begin
      tick(1);
      if (n == 32) begin
        checks++;
        if (oStageRst_n !== 4'b0001 || oFault !== 1'b0) begin
          errors++;
          $display("FAIL ack_pre_tmo rst=%b fault=%b expected 0001/0", oStageRst_n, oFault);
        end
      end else if (n >= 33) begin
        checks++;
        if (oStageRst_n !== 4'b0000 || oFault !== 1'b1 || oDone !== 1'b0) begin
          errors++;
          $display("FAIL ack_tmo E0+%0d rst=%b fault=%b done=%b expected 0000/1/0", n, oStageRst_n, oFault, oDone);
        end
      end
    end
    iRst_n = 1'b0;
    tick(1);
    checks++;
    if (oFault !== 1'b0) begin
      errors++;
      $display("FAIL ack_fault_clear fault=%b expected 0", oFault);
    end
    iRst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
`ifdef POR_SEQ_ACK_EN
    test_ack_timeout();
`else
    test_timed_sequence();
    test_pg_drop();
    test_no_pwrgood();
    test_rst_req();
    test_rst_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
